// File: rtl/counter_sched_if.sv
// Bundle of requester-side and counter-side signals for counter_sched.
// master = clients plus counter datapath, slave = the scheduler itself.
interface counter_sched_if #(
    parameter int NREQ = 4,
    parameter int CW   = 12,
    parameter int LW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic               done;
    logic [CW-1:0]      delta;
    logic               busy;
    logic               cnt_rdy;
    logic               cnt_en;
    logic [CW-1:0]      cnt_val;

    modport master (
        output req, len, cnt_rdy, cnt_val,
        input  gnt, done, delta, busy, cnt_en
    );

    modport slave (
        input  req, len, cnt_rdy, cnt_val,
        output gnt, done, delta, busy, cnt_en
    );
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one counter among NREQ requesters for N-enable windows.
// Define COUNTER_SCHED_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
//
// state    | meaning
// WAIT_RDY | after reset, waiting for the first cnt_rdy
// ARB      | pick a requester, latch its grant and window length
// START    | capture the start count, load the run counter
// RUN      | enable the counter on every ready cycle until rc is used up
// SETTLE   | counter idle for one cycle so cnt_val shows the last increment
// REPORT   | present delta with done, advance the round-robin pointer
module counter_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 12,
    parameter int LW   = 8
) (
    input  logic          clock,
    input  logic          rst,
    counter_sched_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        WAIT_RDY,
        ARB,
        START,
        RUN,
        SETTLE,
        REPORT
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   rc_q, rc_d;
    logic [CW-1:0]   start_q, start_d;
    logic [CW-1:0]   delta_q, delta_d;
    logic [CW-1:0]   diff;
    logic [CW-1:0]   delta_o;
    logic [PW-1:0]   sel;
    logic            found;
    logic            cnt_en;
    logic            done;

`ifndef COUNTER_SCHED_FIXED_PRI_EN
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction
`endif

    // Walk downward so the last hit wins, i.e. the nearest candidate is kept.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
`ifdef COUNTER_SCHED_FIXED_PRI_EN
            if (bus.req[i]) begin
                found = 1'b1;
                sel   = PW'(i);
            end
`else
            if (bus.req[wrap_idx(ptr_q, i)]) begin
                found = 1'b1;
                sel   = wrap_idx(ptr_q, i);
            end
`endif
        end
    end

    assign diff = bus.cnt_val - start_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        len_d   = len_q;
        rc_d    = rc_q;
        start_d = start_q;
        delta_d = delta_q;
        delta_o = delta_q;
        cnt_en  = 1'b0;
        done    = 1'b0;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
`endif
        case (state_q)
            WAIT_RDY: begin
                if (bus.cnt_rdy) state_d = ARB;
            end
            ARB: begin
                if (found) begin
                    gnt_d   = NREQ'(1) << sel;
                    len_d   = bus.len[int'(sel)*LW +: LW];
`ifndef COUNTER_SCHED_FIXED_PRI_EN
                    gidx_d  = sel;
`endif
                    state_d = START;
                end
            end
            START: begin
                start_d = bus.cnt_val;
                rc_d    = len_q;
                state_d = (len_q == '0) ? SETTLE : RUN;
            end
            RUN: begin
                if (bus.cnt_rdy) begin
                    cnt_en = 1'b1;
                    rc_d   = rc_q - LW'(1);
                    if (rc_q == LW'(1)) state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = REPORT;
            end
            REPORT: begin
                done    = 1'b1;
                delta_d = diff;
                delta_o = diff;
                gnt_d   = '0;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
                ptr_d   = wrap_idx(gidx_q, 1);
`endif
                state_d = ARB;
            end
            default: begin
                state_d = WAIT_RDY;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_RDY;
            gnt_q   <= '0;
            len_q   <= '0;
            rc_q    <= '0;
            start_q <= '0;
            delta_q <= '0;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
            ptr_q   <= '0;
            gidx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            rc_q    <= rc_d;
            start_q <= start_d;
            delta_q <= delta_d;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
`endif
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done;
    assign bus.delta  = delta_o;
    assign bus.cnt_en = cnt_en;
    assign bus.busy   = !((state_q == WAIT_RDY) || (state_q == ARB));
endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: vector table plus hand sequences, done-side scoreboard.
module tb_counter_sched;
    localparam int NREQ = 4;
    localparam int CW   = 12;
    localparam int LW   = 8;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    counter_sched_if #(.NREQ(NREQ), .CW(CW), .LW(LW)) bus ();

    counter_sched #(.NREQ(NREQ), .CW(CW), .LW(LW)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    // Counter datapath model with a preload port
    logic [CW-1:0] cnt  = '0;
    logic          ld   = 1'b0;
    logic [CW-1:0] ld_v = '0;
    always @(posedge clock) begin
        if (ld) cnt <= ld_v;
        else if (bus.cnt_en) cnt <= cnt + 1'b1;
    end
    assign bus.cnt_val = cnt;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [CW-1:0]   delta;
        int              nen;
        int              lat;
        int              gap;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*LW-1:0] len;
        logic [NREQ-1:0]    gnt;
        logic [CW-1:0]      delta;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[7];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Done-side monitor: pops the scoreboard on every done pulse
    int cyc = 0, nen = 0, gnt_cyc = 0, last_done = -100;
    logic [NREQ-1:0] prev_gnt = '0;
    always @(negedge clock) begin
        cyc++;
        if (bus.gnt != '0 && prev_gnt == '0) begin
            gnt_cyc = cyc;
            nen     = 0;
        end
        prev_gnt = bus.gnt;
        if (bus.cnt_en) nen++;
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("done_gnt", 32'(bus.gnt), 32'(mon_e.gnt));
                check("delta", 32'(bus.delta), 32'(mon_e.delta));
                check("enables", nen, mon_e.nen);
                check("latency", cyc - gnt_cyc, mon_e.lat);
                if (mon_e.gap > 0) check("done_gap", cyc - last_done, mon_e.gap);
            end
            last_done = cyc;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_gnt(input int budget);
        for (int i = 0; i < budget && bus.gnt == '0; i++) step();
        check("gnt_wait", 32'(bus.gnt != '0), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'b0110, {8'd0, 8'd9, 8'd3, 8'd0}, 4'b0010, 12'd3};
        vt[1] = '{4'b0011, {8'd0, 8'd0, 8'd6, 8'd1}, 4'b0001, 12'd1};
        vt[2] = '{4'b1001, {8'd7, 8'd0, 8'd0, 8'd4}, 4'b1000, 12'd7};
        vt[3] = '{4'b0100, {8'd5, 8'd0, 8'd0, 8'd5}, 4'b0100, 12'd0};
        vt[4] = '{4'b0101, {8'd0, 8'd3, 8'd0, 8'd2}, 4'b0001, 12'd2};
        vt[5] = '{4'b1100, {8'd6, 8'd4, 8'd0, 8'd0}, 4'b0100, 12'd4};
        vt[6] = '{4'b1111, {8'd1, 8'd2, 8'd3, 8'd4}, 4'b1000, 12'd1};

        bus.req = '0;
        bus.len = '0;
        bus.cnt_rdy = 1'b0;
        step();
        step();
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_delta", 32'(bus.delta), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cnt_en", 32'(bus.cnt_en), 32'd0);
        rst = 1'b1;

        // Not ready yet: nothing may move
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait_busy", 32'(bus.busy), 32'd0);
            check("wait_gnt", 32'(bus.gnt), 32'd0);
            check("wait_cnt_en", 32'(bus.cnt_en), 32'd0);
        end
        bus.cnt_rdy = 1'b1;
        bus.req = 4'b0001;
        bus.len = {8'd0, 8'd0, 8'd0, 8'd5};
        sb.push_back('{4'b0001, 12'd5, 5, 7, -1});
        step();
        check("gnt_early", 32'(bus.gnt), 32'd0);
        step();
        check("gnt_2cyc", 32'(bus.gnt), 32'b0001);
        check("busy_start", 32'(bus.busy), 32'd1);
        bus.req = '0;
        wait_drain(100);

        // Single transactions; round-robin pointer carries across entries
        for (int v = 0; v < 7; v++) begin
            bus.len = vt[v].len;
            bus.req = vt[v].req;
            sb.push_back('{vt[v].gnt, vt[v].delta, int'(vt[v].delta), int'(vt[v].delta) + 2, -1});
            wait_gnt(20);
            bus.req = '0;
            wait_drain(300);
        end

        // Round-robin from ptr=0 with all four requesting
        bus.len = {8'd2, 8'd2, 8'd2, 8'd2};
        bus.req = 4'b1111;
        sb.push_back('{4'b0001, 12'd2, 2, 4, -1});
        sb.push_back('{4'b0010, 12'd2, 2, 4, 6});
        sb.push_back('{4'b0100, 12'd2, 2, 4, 6});
        sb.push_back('{4'b1000, 12'd2, 2, 4, 6});
        for (int i = 0; i < 100 && bus.gnt != 4'b1000; i++) step();
        check("rr_last_gnt", 32'(bus.gnt), 32'b1000);
        bus.req = '0;
        wait_drain(100);

        // Stall for 3 cycles after the second enable
        bus.len = {8'd0, 8'd0, 8'd0, 8'd4};
        bus.req = 4'b0001;
        sb.push_back('{4'b0001, 12'd4, 4, 9, -1});
        wait_gnt(20);
        bus.req = '0;
        step();
        step();
        step();
        bus.cnt_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_en", 32'(bus.cnt_en), 32'd0);
            check("stall_busy", 32'(bus.busy), 32'd1);
            step();
        end
        bus.cnt_rdy = 1'b1;
        wait_drain(100);

        // Counter wrap-around
        ld_v = 12'hFFE;
        ld = 1'b1;
        step();
        ld = 1'b0;
        bus.len = {8'd0, 8'd0, 8'd5, 8'd9};
        bus.req = 4'b0010;
        sb.push_back('{4'b0010, 12'd5, 5, 7, -1});
        wait_gnt(20);
        bus.req = '0;
        wait_drain(100);
        check("wrap_cnt", 32'(cnt), 32'h003);
        check("delta_hold", 32'(bus.delta), 32'd5);

        // Reset in the middle of RUN
        bus.len = {8'd10, 8'd0, 8'd0, 8'd0};
        bus.req = 4'b1000;
        wait_gnt(20);
        check("mid_gnt", 32'(bus.gnt), 32'b1000);
        bus.req = '0;
        step();
        step();
        step();
        check("mid_running", 32'(bus.cnt_en), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("mid_cnt_en", 32'(bus.cnt_en), 32'd0);
        check("mid_gnt_clr", 32'(bus.gnt), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_done", 32'(bus.done), 32'd0);
        step();
        step();
        check("mid_sb", sb.size(), 0);
        rst = 1'b1;
        step();
        check("mid_idle_busy", 32'(bus.busy), 32'd0);

        // ptr must be back at 0: all requesting, requester 0 wins
        bus.len = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.req = 4'b1111;
        sb.push_back('{4'b0001, 12'd1, 1, 3, -1});
        wait_gnt(20);
        bus.req = '0;
        wait_drain(100);

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
